// File: rtl/spm_multi_pkg.sv
// Shared types and sizing helpers for the multi-lane serial multiplier.
package spm_multi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int PW        = 2 * DEF_WIDTH;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/spm_lane.sv
// One serial shift-add multiplier lane: consumes one multiplier bit per step, LSB first.
module spm_lane
  import spm_multi_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               last,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   xin,
  input  logic [WIDTH-1:0]   yin,
  output logic [2*WIDTH-1:0] res
);

  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH:0]   addend_s;
  logic [WIDTH:0]   sum_s;
  logic             fill_s;

  // Partial-sum datapath; the signed final step carries weight -2^(WIDTH-1), hence subtract.
  always_comb begin
    addend_s = y_r[0] ? {sgn & x_r[WIDTH-1], x_r} : {(WIDTH+1){1'b0}};
    sum_s    = (last && sgn) ? (acc_r - addend_s) : (acc_r + addend_s);
    fill_s   = sgn ? sum_s[WIDTH] : 1'b0;
    res      = {sum_s, y_r[WIDTH-1:1]};
  end

  // Operand capture on load, then shift the accumulator/multiplier pair right each step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r   <= {WIDTH{1'b0}};
      y_r   <= {WIDTH{1'b0}};
      acc_r <= {(WIDTH+1){1'b0}};
    end else if (load) begin
      x_r   <= xin;
      y_r   <= yin;
      acc_r <= {(WIDTH+1){1'b0}};
    end else if (step) begin
      acc_r <= {fill_s, sum_s[WIDTH:1]};
      y_r   <= {sum_s[0], y_r[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/spm_multi.sv
// Multi-channel serial multiplier: one shared FSM/counter sequencing CHANNELS spm_lane instances.
module spm_multi
  import spm_multi_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         signed_mode,
  input  logic [CHANNELS-1:0]          ch_en,
  input  logic [CHANNELS*WIDTH-1:0]    x,
  input  logic [CHANNELS*WIDTH-1:0]    y,
  output logic                         busy,
  output logic                         done,
  output logic [CHANNELS*2*WIDTH-1:0]  prod,
  output logic [CHANNELS-1:0]          prod_valid
);

  localparam int CW  = cnt_width(WIDTH);
  localparam int LPW = 2 * WIDTH;

  state_t                    state_r;
  logic [CW-1:0]             cnt_r;
  logic                      sgn_r;
  logic [CHANNELS-1:0]       en_r;
  logic                      accept_s;
  logic                      step_s;
  logic                      last_s;
  logic [CHANNELS*LPW-1:0]   res_s;

  assign accept_s = start && (state_r != RUN);
  assign step_s   = (state_r == RUN);
  assign last_s   = step_s && (cnt_r == CW'(WIDTH - 1));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    spm_lane #(.WIDTH(WIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (accept_s),
      .step (step_s),
      .last (last_s),
      .sgn  (sgn_r),
      .xin  (x[i*WIDTH +: WIDTH]),
      .yin  (y[i*WIDTH +: WIDTH]),
      .res  (res_s[i*LPW +: LPW])
    );
  end

  // Control FSM; the last step edge also commits results so DONE can accept the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      sgn_r      <= 1'b0;
      en_r       <= {CHANNELS{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      prod       <= {(CHANNELS*LPW){1'b0}};
      prod_valid <= {CHANNELS{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r    <= RUN;
            busy       <= 1'b1;
            cnt_r      <= {CW{1'b0}};
            sgn_r      <= signed_mode;
            en_r       <= ch_en;
            prod_valid <= {CHANNELS{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (last_s) begin
            state_r    <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            prod_valid <= en_r;
            for (int i = 0; i < CHANNELS; i++) begin
              if (en_r[i]) begin
                prod[i*LPW +: LPW] <= res_s[i*LPW +: LPW];
              end
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
